psk_mod: RTL
============

Name: psk_mod

Overview:
Parametrised successor to the single-bit BPSK modulator. It accepts parallel data words over a valid/ready handshake and serialises them MSB-first into symbols. Each symbol is held for a programmable number of samples, and the symbols are mapped onto externally supplied sine/cosine carriers in BPSK or QPSK mode. It sits between the framing logic and the DAC interface, and emits one registered two's-complement sample per clock while transmitting.

Parameters:
OUTPUT_WIDTH, 12, width of the carrier inputs and of dac_out (two's complement).
DATA_WIDTH, 8, input word width; must be even.
SPS_WIDTH, 8, width of the samples-per-symbol control.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous reset, active-high.
mode  in  1  0 = BPSK (1 bit/symbol), 1 = QPSK (2 bits/symbol); latched at word accept.
sps  in  SPS_WIDTH  samples per symbol; 0 and 1 both mean 1; latched at word accept.
s_data  in  DATA_WIDTH  word to transmit, MSB first.
s_valid  in  1  s_data valid.
s_ready  out  1  block can accept a word this cycle (combinational).
sine_c  in  OUTPUT_WIDTH  signed sine carrier sample.
cosine_c  in  OUTPUT_WIDTH  signed cosine carrier sample.
dac_out  out  OUTPUT_WIDTH  registered signed modulated sample.
dac_valid  out  1  registered; dac_out is a transmitted sample.
busy  out  1  registered; high while state is TX.

Behaviour:
- Reset: while rst is sampled high at a clk edge, the following are cleared: state=IDLE, dac_out=0, dac_valid=0, busy=0, shift register, symbol counter and sample counter. Applies mid-word too: the current word is dropped and no further samples are produced for it.
- States: IDLE and TX.
- s_ready = (state==IDLE) OR (state==TX AND the current cycle produces the last sample of the last symbol of the word).
- Accept: occurs when s_valid & s_ready at an edge. On accept:
  - load s_data, latch mode and sps_eff = max(sps,1);
  - clear both counters; state becomes TX.
- Symbols per word: DATA_WIDTH in BPSK, DATA_WIDTH/2 in QPSK. QPSK takes the first bit of each pair as I and the second as Q.
- Timing: in TX, each edge registers one sample, using the current symbol and the sine_c/cosine_c values present at that edge.
  - Each symbol produces exactly sps_eff consecutive samples; the sample counter wraps 0..sps_eff-1.
  - On wrap, the shift register advances 1 bit (BPSK) or 2 bits (QPSK).
  - The first sample of a word is registered on the edge after the accept edge (latency 1).
- Word end:
  - If a new word is accepted at the edge that registers the final sample, TX continues with no gap. The new word's first sample follows on the next edge.
  - Otherwise state returns to IDLE, and the next edge registers dac_out=0, dac_valid=0.
- BPSK mapping: bit 1 gives sine_c; bit 0 gives -sine_c.
- QPSK mapping:
  - I term = I ? cosine_c : -cosine_c; Q term = Q ? sine_c : -sine_c.
  - Sum in OUTPUT_WIDTH+1 bits, arithmetic shift right by 1 (floor), truncate to OUTPUT_WIDTH.
- Negation saturates: -(−2^(W-1)) = 2^(W-1)-1. All other negations are exact two's complement.
- dac_valid=1 exactly on samples produced in TX. In IDLE, dac_out is held at 0.
- busy is registered and equals (state==TX).
- Changes to mode/sps during TX do not affect the word in flight.

Test Plan:
1. Reset: assert rst 2 cycles with random inputs → dac_out=0, dac_valid=0, busy=0, s_ready=1.
2. BPSK, sps=2, s_data=0xA5, sine_c=100 constant → 16 valid samples: 100,100,-100,-100,100,100,-100,-100,-100,-100,100,100,-100,-100,100,100. Then dac_valid=0, dac_out=0.
3. QPSK, sps=1, s_data=0x9C, cosine_c=200, sine_c=100 → 4 samples 50, -50, 150, -150 (12-bit: 0x032, 0xFCE, 0x096, 0xF6A).
4. Saturation: BPSK, sps=1, s_data=0x00, sine_c=-2048 → 8 samples of 2047 (0x7FF).
5. Back-to-back: BPSK, sps=3, s_valid held high with 0xFF then 0x00, sine_c=5 → s_ready pulses high only on the 24th sample cycle. Result: 24 samples of 5 then 24 samples of -5, dac_valid never drops between words.
6. Mid-word reset and sps=0: start BPSK 0xF0 with sps=0 → one sample per bit. Assert rst after the 3rd sample → next edge dac_out=0, dac_valid=0, and a new accept restarts from the MSB of the new word.

Source files
------------

// File: rtl/psk_mod.sv
// BPSK/QPSK modulator: accepts parallel words over valid/ready, serialises them MSB-first
// into symbols held for sps samples, and maps each symbol onto the supplied carriers.
module psk_mod #(
  parameter int OUTPUT_WIDTH = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int SPS_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mode,
  input  logic        [SPS_WIDTH-1:0]    sps,
  input  logic        [DATA_WIDTH-1:0]   s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic signed [OUTPUT_WIDTH-1:0] sine_c,
  input  logic signed [OUTPUT_WIDTH-1:0] cosine_c,
  output logic signed [OUTPUT_WIDTH-1:0] dac_out,
  output logic                           dac_valid,
  output logic                           busy
);

  localparam int W     = OUTPUT_WIDTH;
  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] LAST_SYM_BPSK = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_SYM_QPSK = CNT_W'(DATA_WIDTH / 2 - 1);
  localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};

  typedef enum logic {
    IDLE = 1'b0,
    TX   = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    mode_reg;
  logic [SPS_WIDTH-1:0]    sps_reg;
  logic [SPS_WIDTH-1:0]    samp_cnt_reg;
  logic [CNT_W-1:0]        sym_cnt_reg;
  logic signed [W-1:0]     dac_out_reg;
  logic                    dac_valid_reg;
  logic                    busy_reg;

  logic                    last_samp;
  logic                    last_sym;
  logic                    word_end;
  logic                    accept;
  logic [SPS_WIDTH-1:0]    sps_eff;

  // The most negative code has no positive counterpart; clamp it to full scale.
  function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] x);
    if (x == MIN_VAL) begin
      return MAX_VAL;
    end
    return -x;
  endfunction

  assign sps_eff   = (sps == '0) ? SPS_WIDTH'(1) : sps;
  assign last_samp = (samp_cnt_reg == sps_reg - SPS_WIDTH'(1));
  assign last_sym  = (sym_cnt_reg == (mode_reg ? LAST_SYM_QPSK : LAST_SYM_BPSK));
  assign word_end  = last_samp && last_sym;
  assign accept    = s_valid && s_ready;

  // Carrier lanes: lane 0 is sine (BPSK symbol or QPSK Q bit), lane 1 is cosine (QPSK I bit).
  logic signed [W-1:0] carrier [2];
  logic                lane_bit [2];
  logic signed [W-1:0] term [2];

  assign carrier[0]  = sine_c;
  assign carrier[1]  = cosine_c;
  assign lane_bit[0] = mode_reg ? shift_reg[DATA_WIDTH-2] : shift_reg[DATA_WIDTH-1];
  assign lane_bit[1] = shift_reg[DATA_WIDTH-1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign term[gi] = lane_bit[gi] ? carrier[gi] : sat_neg(carrier[gi]);
    end
  endgenerate

  // Bits [W:1] of the widened sum are the floor-halved result truncated to W bits.
  logic signed [W:0]   qpsk_sum;
  logic signed [W-1:0] qpsk_sample;
  logic signed [W-1:0] sample_next;

  assign qpsk_sum    = {term[1][W-1], term[1]} + {term[0][W-1], term[0]};
  assign qpsk_sample = qpsk_sum[W:1];
  assign sample_next = mode_reg ? qpsk_sample : term[0];

  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    case (state_reg)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          state_next = TX;
        end
      end
      TX: begin
        s_ready = word_end;
        if (word_end && !s_valid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg    <= '0;
      mode_reg     <= 1'b0;
      sps_reg      <= SPS_WIDTH'(1);
      samp_cnt_reg <= '0;
      sym_cnt_reg  <= '0;
    end else if (accept) begin
      shift_reg    <= s_data;
      mode_reg     <= mode;
      sps_reg      <= sps_eff;
      samp_cnt_reg <= '0;
      sym_cnt_reg  <= '0;
    end else if (state_reg == TX) begin
      if (last_samp) begin
        samp_cnt_reg <= '0;
        sym_cnt_reg  <= sym_cnt_reg + CNT_W'(1);
        shift_reg    <= mode_reg ? {shift_reg[DATA_WIDTH-3:0], 2'b00}
                                 : {shift_reg[DATA_WIDTH-2:0], 1'b0};
      end else begin
        samp_cnt_reg <= samp_cnt_reg + SPS_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dac_out_reg   <= '0;
      dac_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      busy_reg <= (state_next == TX);
      if (state_reg == TX) begin
        dac_out_reg   <= sample_next;
        dac_valid_reg <= 1'b1;
      end else begin
        dac_out_reg   <= '0;
        dac_valid_reg <= 1'b0;
      end
    end
  end

  assign dac_out   = dac_out_reg;
  assign dac_valid = dac_valid_reg;
  assign busy      = busy_reg;

endmodule
